alu_muldiv_sequencer: RTL

- Multi-cycle controller that computes unsigned 32-bit multiply and divide by driving the existing single-cycle ALU over many clock cycles.
- Sits beside the ALU in the execute stage and owns the ALU control and operand inputs while busy.
- Multiply uses iterative ADD; divide uses restoring SLT/SUB.
- Gives the core a start/busy/done handshake so the pipeline can stall on mul/div instructions.

---
 rtl/alu_muldiv_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle unsigned multiply/divide controller that borrows the execute-stage ALU:
// shift-and-add multiply (32 ADD cycles) and restoring divide (32 SLT/SUB pairs).
module alu_muldiv_sequencer #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] DZ_QUOT = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_zero,
    output logic [3:0]       alu_cnt,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [WIDTH-1:0] alu_in3,
    output logic [4:0]       alu_shamt,
    input  logic [WIDTH-1:0] alu_result
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_MUL     = 3'd1;
    localparam logic [2:0] S_DIV_CMP = 3'd2;
    localparam logic [2:0] S_DIV_SUB = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [4:0] LAST_CNT = 5'(WIDTH - 1);

    logic [2:0]       state_reg;
    logic [4:0]       cnt_reg;
    logic [WIDTH-1:0] acc_reg, mc_reg, mp_reg;
    logic [WIDTH-1:0] rem_reg, dvd_reg, q_reg, dvs_reg;
    logic             lt_reg;

    logic [WIDTH-1:0] shifted_rem;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] rem_next;

    // Shift the next dividend bit into the partial remainder; rem_reg's MSB is the carry out.
    assign shifted_rem = {rem_reg[WIDTH-2:0], dvd_reg[WIDTH-1]};
    assign q_next      = {q_reg[WIDTH-2:0], ~lt_reg};
    assign rem_next    = lt_reg ? rem_reg : alu_result;

    assign busy      = (state_reg == S_MUL) || (state_reg == S_DIV_CMP) || (state_reg == S_DIV_SUB);
    assign done      = (state_reg == S_DONE);
    assign alu_in3   = '0;
    assign alu_shamt = '0;

    always_comb begin
        alu_cnt = ALU_ADD;
        alu_in1 = '0;
        alu_in2 = '0;
        case (state_reg)
            S_MUL: begin
                alu_cnt = ALU_ADD;
                alu_in1 = acc_reg;
                alu_in2 = mp_reg[0] ? mc_reg : '0;
            end
            S_DIV_CMP: begin
                alu_cnt = ALU_SLT;
                alu_in1 = shifted_rem;
                alu_in2 = dvs_reg;
            end
            S_DIV_SUB: begin
                alu_cnt = ALU_SUB;
                alu_in1 = rem_reg;
                alu_in2 = dvs_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            mc_reg    <= '0;
            mp_reg    <= '0;
            rem_reg   <= '0;
            dvd_reg   <= '0;
            q_reg     <= '0;
            dvs_reg   <= '0;
            lt_reg    <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        cnt_reg   <= '0;
                        result_lo <= '0;
                        result_hi <= '0;
                        div_zero  <= 1'b0;
                        if (!op) begin
                            acc_reg   <= '0;
                            mc_reg    <= opa;
                            mp_reg    <= opb;
                            state_reg <= S_MUL;
                        end else if (opb != '0) begin
                            rem_reg   <= '0;
                            dvd_reg   <= opa;
                            q_reg     <= '0;
                            dvs_reg   <= opb;
                            state_reg <= S_DIV_CMP;
                        end else begin
                            result_lo <= DZ_QUOT;
                            result_hi <= opa;
                            div_zero  <= 1'b1;
                            state_reg <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    acc_reg <= alu_result;
                    mc_reg  <= mc_reg << 1;
                    mp_reg  <= mp_reg >> 1;
                    cnt_reg <= cnt_reg + 5'd1;
                    if (cnt_reg == LAST_CNT) begin
                        result_lo <= alu_result;
                        state_reg <= S_DONE;
                    end
                end
                S_DIV_CMP: begin
                    // A carried-out bit means the true partial remainder exceeds any divisor.
                    lt_reg    <= ~rem_reg[WIDTH-1] & alu_result[0];
                    rem_reg   <= shifted_rem;
                    dvd_reg   <= dvd_reg << 1;
                    state_reg <= S_DIV_SUB;
                end
                S_DIV_SUB: begin
                    rem_reg <= rem_next;
                    q_reg   <= q_next;
                    cnt_reg <= cnt_reg + 5'd1;
                    if (cnt_reg == LAST_CNT) begin
                        result_lo <= q_next;
                        result_hi <= rem_next;
                        state_reg <= S_DONE;
                    end else begin
                        state_reg <= S_DIV_CMP;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule
